// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 round-robin stream mux with packet locking and source id tagging
module rr_stream_mux #(
    parameter int WIDTH = 8,
    parameter int N = 4,
    parameter int ID_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [ID_W-1:0]    out_id,
    output logic               out_last
);
    localparam int PW = $clog2(N);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state;
    logic [PW-1:0] ptr, lock_ch, gnt, gnt_next;
    logic [PW:0] cand;
    logic found, load;
    assign load = ~out_valid | out_ready;
    assign gnt_next = (gnt == PW'(N - 1)) ? '0 : gnt + 1'b1;
    assign in_ready = (rst_n && load && found) ? (N)'(1) << gnt : '0;
    // Grant the locked channel, or the first requester at or after ptr (descending scan, lowest offset wins)
    always_comb begin
        gnt = lock_ch;
        found = in_valid[lock_ch];
        cand = '0;
        if (state == IDLE) begin
            found = 1'b0;
            for (int k = N - 1; k >= 0; k--) begin
                cand = {1'b0, ptr} + (PW+1)'(k);
                cand = (cand >= (PW+1)'(N)) ? cand - (PW+1)'(N) : cand;
                if (in_valid[cand[PW-1:0]]) begin
                    gnt = cand[PW-1:0];
                    found = 1'b1;
                end
            end
        end
    end
    // Output register and arbiter state advance together whenever the output slot can take a beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
            lock_ch   <= '0;
            state     <= IDLE;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= in_data[gnt*WIDTH +: WIDTH];
                out_id   <= ID_W'(gnt);
                out_last <= in_last[gnt];
                if (in_last[gnt]) begin
                    state <= IDLE;
                    ptr   <= gnt_next;
                end else begin
                    state   <= LOCKED;
                    lock_ch <= gnt;
                end
            end
        end
    end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: scoreboard bench for the round-robin stream mux
module tb_rr_stream_mux;
    typedef struct packed {
        logic [1:0] id;
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [7:0]  out_data;
    logic [1:0]  out_id;

    beat_t       exp_q[$];
    logic [8:0]  txm[4][32];
    int          head[4], tail[4];
    logic [3:0]  gap, hs_mask;
    bit          drv_en;
    int          checks, errors;

    rr_stream_mux #(.WIDTH(8), .N(4), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic void drive();
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = (head[i] != tail[i]) && !gap[i];
            in_data[i*8 +: 8] = txm[i][head[i]][7:0];
            in_last[i] = txm[i][head[i]][8];
        end
    endfunction

    function automatic void push_tx(int ch, logic [7:0] d, logic l);
        txm[ch][tail[ch]] = {l, d};
        tail[ch]++;
    endfunction

    function automatic void push_exp(int ch, logic [7:0] d, logic l);
        exp_q.push_back({2'(ch), l, d});
    endfunction

    // Monitor: sample handshakes and score output beats at the falling edge
    always @(negedge clk) begin
        beat_t e;
        hs_mask = rst_n ? (in_valid & in_ready) : 4'b0;
        checks++;
        if ($countones(in_ready) > 1) begin
            errors++;
            $display("FAIL onehot: in_ready=%b, required at most one bit", in_ready);
        end
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: id=%0d last=%b data=%h, required no beat", out_id, out_last, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_id, out_last, out_data} !== e) begin
                    errors++;
                    $display("FAIL beat: id=%0d last=%b data=%h, required id=%0d last=%b data=%h",
                             out_id, out_last, out_data, e.id, e.last, e.data);
                end
            end
        end
    end

    // Driver: retire handshaken beats just after the rising edge and present the next ones
    always @(posedge clk) begin
        #1;
        if (drv_en) begin
            for (int i = 0; i < 4; i++)
                if (hs_mask[i] && head[i] != tail[i]) head[i]++;
            drive();
        end
    end

    task automatic wait_drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drv_en = 1'b0;
        out_ready = 1'b1;
        in_valid = 4'hF;
        in_data = {4{8'hAA}};
        in_last = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_id, out_last} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h id=%0d last=%b, required all zero", out_valid, out_data, out_id, out_last);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready: %b, required 0000", in_ready);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA || out_id !== 2'd0) begin
            errors++;
            $display("FAIL first_load: valid=%b data=%h id=%0d, required 1 aa 0", out_valid, out_data, out_id);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h last=%b, required 0 00 0", out_valid, out_data, out_last);
        end
        gap = 4'b0;
        drv_en = 1'b1;
        drive();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        int nvalid = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                push_tx(c, 8'h10 + 8'(c), 1'b1);
                push_exp(c, 8'h10 + 8'(c), 1'b1);
            end
        drive();
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nvalid += int'(out_valid);
        end
        checks++;
        if (nvalid != 8) begin
            errors++;
            $display("FAIL rotation_throughput: %0d valid beats in 8 cycles, required 8", nvalid);
        end
        wait_drain("rotation");
    endtask

    task automatic test_lock();
        push_tx(1, 8'h21, 1'b0); push_exp(1, 8'h21, 1'b0);
        push_tx(1, 8'h22, 1'b0); push_exp(1, 8'h22, 1'b0);
        push_tx(1, 8'h23, 1'b1); push_exp(1, 8'h23, 1'b1);
        push_tx(2, 8'h2A, 1'b1); push_exp(2, 8'h2A, 1'b1);
        drive();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (in_ready[2] !== 1'b0) begin
                errors++;
                $display("FAIL lock_starve: in_ready=%b, required ch2 bit 0", in_ready);
            end
        end
        wait_drain("lock");
        push_tx(1, 8'h24, 1'b0); push_exp(1, 8'h24, 1'b0);
        push_tx(1, 8'h25, 1'b0); push_exp(1, 8'h25, 1'b0);
        push_tx(1, 8'h26, 1'b1); push_exp(1, 8'h26, 1'b1);
        push_tx(2, 8'h2B, 1'b1); push_exp(2, 8'h2B, 1'b1);
        drive();
        @(posedge clk);
        #2;
        gap[1] = 1'b1;
        drive();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL lock_bubble: valid=%b in_ready=%b, required 0 0000", out_valid, in_ready);
        end
        #1;
        gap[1] = 1'b0;
        drive();
        wait_drain("lock_gap");
    endtask

    task automatic test_backpressure();
        push_tx(3, 8'h3C, 1'b1); push_exp(3, 8'h3C, 1'b1);
        push_tx(0, 8'h40, 1'b1); push_exp(0, 8'h40, 1'b1);
        drive();
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || out_id !== 2'd3 || in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h id=%0d in_ready=%b, required 1 3c 3 0000",
                         out_valid, out_data, out_id, in_ready);
            end
        end
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h40 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL stall_release: valid=%b data=%h id=%0d, required 1 40 0", out_valid, out_data, out_id);
        end
        wait_drain("backpressure");
    endtask

    task automatic test_ptr_skip();
        push_tx(0, 8'h50, 1'b1); push_exp(0, 8'h50, 1'b1);
        drive();
        wait_drain("ptr_prime");
        push_tx(0, 8'h51, 1'b1);
        push_tx(2, 8'h52, 1'b1);
        push_exp(2, 8'h52, 1'b1);
        push_exp(0, 8'h51, 1'b1);
        drive();
        @(posedge clk);
        #1;
        checks++;
        if (out_id !== 2'd2) begin
            errors++;
            $display("FAIL ptr_skip: id=%0d, required 2", out_id);
        end
        wait_drain("ptr_skip");
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 4; b++) push_tx(2, 8'h60 + 8'(b), b == 3);
        push_exp(2, 8'h60, 1'b0);
        push_exp(2, 8'h61, 1'b0);
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_clear: valid=%b data=%h in_ready=%b, required 0 00 0000", out_valid, out_data, in_ready);
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) head[i] = tail[i];
        push_tx(1, 8'h71, 1'b1); push_exp(1, 8'h71, 1'b1);
        push_tx(2, 8'h72, 1'b1); push_exp(2, 8'h72, 1'b1);
        drive();
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_ready: in_ready=%b, required 0000", in_ready);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_drain("reset_mid");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        gap = 4'b0;
        hs_mask = 4'b0;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        test_reset();
        test_rotation();
        test_lock();
        test_backpressure();
        test_ptr_skip();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
